vm_console_ctrl: RTL and testbench

VM_CONSOLE_CTRL -- requirements
Module: vm_console_ctrl

---
 rtl/vm_console_ctrl.sv | 152 +++++++++++++++
 tb/tb_vm_console_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_console_ctrl.sv
// Text console controller for video memory port A: the CPU writes cells directly, and an engine
// runs clear-screen and scroll-up-one-row commands whenever the CPU leaves the port idle.
module vm_console_ctrl #(
    parameter int COLS = 32,
    parameter int ROWS = 30
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic [9:0]  cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cmd_clr,
    input  logic        cmd_scroll,
    input  logic [7:0]  fill_char,
    input  logic [7:0]  vm_dout,
    output logic        vm_we,
    output logic [11:0] vm_addr,
    output logic [7:0]  vm_din,
    output logic        busy,
    output logic        done
);

    localparam logic [9:0] LAST_CELL  = 10'(ROWS * COLS - 1);
    localparam logic [9:0] LAST_ROW   = 10'((ROWS - 1) * COLS);
    localparam logic [9:0] ROW_STRIDE = 10'(COLS);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SC_RD,
        SC_LAT,
        SC_WR,
        SC_FILL
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  ptr_q, ptr_d;
    logic [9:0]  src_q, src_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  fill_q, fill_d;
    logic        done_q, done_d;

    logic        grant;
    logic        eng_we;
    logic [9:0]  eng_addr;
    logic [7:0]  eng_din;

    // The engine only owns the port in cycles the CPU is not writing.
    assign grant = ~cpu_we;

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        src_d    = src_q;
        data_d   = data_q;
        fill_d   = fill_q;
        done_d   = 1'b0;
        eng_we   = 1'b0;
        eng_addr = '0;
        eng_din  = '0;

        case (state_q)
            IDLE: begin
                if (cmd_clr) begin
                    state_d = CLR;
                    ptr_d   = '0;
                    fill_d  = fill_char;
                end else if (cmd_scroll) begin
                    state_d = SC_RD;
                    src_d   = ROW_STRIDE;
                    fill_d  = fill_char;
                end
            end
            CLR: begin
                eng_we   = 1'b1;
                eng_addr = ptr_q;
                eng_din  = fill_q;
                if (grant) begin
                    if (ptr_q == LAST_CELL) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 10'd1;
                    end
                end
            end
            SC_RD: begin
                eng_addr = src_q;
                if (grant) state_d = SC_LAT;
            end
            SC_LAT: begin
                // Read data belongs to the granted SC_RD cycle, so a CPU write now cannot disturb it.
                data_d  = vm_dout;
                state_d = SC_WR;
            end
            SC_WR: begin
                eng_we   = 1'b1;
                eng_addr = src_q - ROW_STRIDE;
                eng_din  = data_q;
                if (grant) begin
                    if (src_q == LAST_CELL) begin
                        state_d = SC_FILL;
                        ptr_d   = LAST_ROW;
                    end else begin
                        src_d   = src_q + 10'd1;
                        state_d = SC_RD;
                    end
                end
            end
            SC_FILL: begin
                eng_we   = 1'b1;
                eng_addr = ptr_q;
                eng_din  = fill_q;
                if (grant) begin
                    if (ptr_q == LAST_CELL) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also masks the write strobe so a CPU write cannot land while the block is held.
    assign vm_we   = ~rst & (cpu_we | eng_we);
    assign vm_addr = {2'b00, (cpu_we ? cpu_addr : eng_addr)};
    assign vm_din  = cpu_we ? cpu_data : eng_din;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_vm_console_ctrl.sv
// Bench for vm_console_ctrl: expected port writes and done events are queued by the stimulus
// and a negedge monitor pops and compares them against what the controller drives.
module tb_vm_console_ctrl;

    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [7:0]  cpu_data;
    logic        cmd_clr;
    logic        cmd_scroll;
    logic [7:0]  fill_char;
    logic [7:0]  vm_dout;
    logic        vm_we;
    logic [11:0] vm_addr;
    logic [7:0]  vm_din;
    logic        busy;
    logic        done;

    always #5 clk_50mhz = ~clk_50mhz;

    vm_console_ctrl #(.COLS(32), .ROWS(30)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cmd_clr   (cmd_clr),
        .cmd_scroll(cmd_scroll),
        .fill_char (fill_char),
        .vm_dout   (vm_dout),
        .vm_we     (vm_we),
        .vm_addr   (vm_addr),
        .vm_din    (vm_din),
        .busy      (busy),
        .done      (done)
    );

    // Video memory port A: write-enabled store, registered read-before-write data.
    logic [7:0] mem [0:1023];
    always @(posedge clk_50mhz) begin
        if (vm_we) mem[vm_addr[9:0]] <= vm_din;
        vm_dout <= mem[vm_addr[9:0]];
    end

    int cyc = 0;
    always @(posedge clk_50mhz) cyc <= cyc + 1;

    typedef struct packed { logic [11:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { int cyc; int bz; } dn_t;

    wr_t        exp_wr [$];
    dn_t        exp_done [$];
    int         cpu_at [$];
    logic [9:0] cpu_ad [$];
    logic [7:0] cpu_dt [$];
    logic [7:0] shadow [0:1023];

    int n_chk  = 0;
    int n_pass = 0;
    int c0     = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [7:0] d);
        wr_t w;
        w.a = {2'b00, a};
        w.d = d;
        exp_wr.push_back(w);
        shadow[a] = d;
    endtask

    task automatic push_done(input int dur);
        dn_t e;
        e.cyc = c0 + 1 + dur;
        e.bz  = dur;
        exp_done.push_back(e);
    endtask

    // Row moves use the pre-scroll image; optional CPU writes slot in at their stream position.
    task automatic push_scroll(input logic [7:0] f, input logic ins);
        logic [7:0] snap [0:1023];
        for (int i = 0; i < 1024; i++) snap[i] = shadow[i];
        for (int s = 32; s <= 959; s++) begin
            if (ins && s == 32) push_wr(10'h020, 8'hEE);
            if (ins && s == 33) push_wr(10'h3F0, 8'h77);
            push_wr(10'(s - 32), snap[s]);
        end
        for (int p = 928; p <= 959; p++) push_wr(10'(p), f);
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic start_cmd(input logic c, input logic s, input logic [7:0] f);
        tick();
        c0         = cyc;
        cmd_clr    = c;
        cmd_scroll = s;
        fill_char  = f;
    endtask

    task automatic cpu_idle_write(input logic [9:0] a, input logic [7:0] d);
        push_wr(a, d);
        tick();
        cpu_we   = 1'b1;
        cpu_addr = a;
        cpu_data = d;
        @(negedge clk_50mhz);
        chk("idle_busy", int'(busy), 0);
        tick();
        cpu_we = 1'b0;
    endtask

    // Drives operation cycle i = 0,1,...; stops when the expected done has been seen or at rst_at.
    task automatic run_op(input int poke, input int rst_at);
        for (int i = 0; i < 4000; i++) begin
            tick();
            cmd_clr    = 1'b0;
            cmd_scroll = 1'b0;
            cpu_we     = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                return;
            end
            if (rst_at < 0 && exp_done.size() == 0) return;
            if (i == poke) begin
                cmd_clr    = 1'b1;
                cmd_scroll = 1'b1;
            end
            if (cpu_at.size() > 0 && cpu_at[0] == i) begin
                cpu_we   = 1'b1;
                cpu_addr = cpu_ad.pop_front();
                cpu_data = cpu_dt.pop_front();
                void'(cpu_at.pop_front());
            end
        end
        if (rst_at < 0) chk("op_timeout_pending_done", exp_done.size(), 0);
    endtask

    // Monitor
    initial begin
        int  busy_cnt;
        wr_t w;
        dn_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk_50mhz);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (vm_we) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write_addr", int'(vm_addr), -1);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", int'(vm_addr), int'(w.a));
                        chk("wr_data", int'(vm_din), int'(w.d));
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done_cycle", cyc, -1);
                    end else begin
                        e = exp_done.pop_front();
                        chk("done_cycle", cyc, e.cyc);
                        chk("busy_cycles", busy_cnt, e.bz);
                        $display("op complete at cycle %0d after %0d busy cycles", cyc, busy_cnt);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        int bad;
        for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
        rst        = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 10'h005;
        cpu_data   = 8'h09;
        cmd_clr    = 1'b0;
        cmd_scroll = 1'b0;
        fill_char  = 8'h00;

        // Reset: outputs quiet, CPU write masked
        @(negedge clk_50mhz);
        chk("rst_vm_we_masked", int'(vm_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        cpu_we = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk_50mhz);
        chk("idle_vm_we", int'(vm_we), 0);
        chk("idle_vm_addr", int'(vm_addr), 0);
        $display("reset checks complete");

        // CPU write in IDLE
        cpu_idle_write(10'h021, 8'h41);
        $display("cpu write 0x021=0x41 issued");

        // Clear with 0x20, ignored command at cycle 100
        for (int p = 0; p <= 959; p++) push_wr(10'(p), 8'h20);
        start_cmd(1'b1, 1'b0, 8'h20);
        push_done(960);
        run_op(100, -1);

        // Scroll with preloaded cells
        cpu_idle_write(10'h020, 8'h55);
        cpu_idle_write(10'h3BF, 8'h66);
        push_scroll(8'h00, 1'b0);
        start_cmd(1'b0, 1'b1, 8'h00);
        push_done(2816);
        run_op(-1, -1);
        chk("scroll_cell_000", int'(mem[10'h000]), 8'h55);
        chk("scroll_cell_39F", int'(mem[10'h39F]), 8'h66);
        chk("scroll_cell_020", int'(mem[10'h020]), 8'h20);
        bad = 0;
        for (int a = 'h3A0; a <= 'h3BF; a++) if (mem[a] != 8'h00) bad++;
        chk("scroll_fill_row_bad_cells", bad, 0);

        // Clear + scroll together (clear wins), CPU writes on cycles 10..14
        for (int p = 0; p <= 9; p++) push_wr(10'(p), 8'h2E);
        for (int k = 0; k < 5; k++) begin
            push_wr(10'(12'h200 + k), 8'(8'hC0 + k));
            cpu_at.push_back(10 + k);
            cpu_ad.push_back(10'(12'h200 + k));
            cpu_dt.push_back(8'(8'hC0 + k));
        end
        for (int p = 10; p <= 959; p++) push_wr(10'(p), 8'h2E);
        start_cmd(1'b1, 1'b1, 8'h2E);
        push_done(965);
        run_op(-1, -1);

        // Scroll with CPU writes during SC_LAT (cycle 1) and SC_WR (cycle 5)
        cpu_idle_write(10'h020, 8'h12);
        cpu_idle_write(10'h021, 8'h34);
        push_scroll(8'hFF, 1'b1);
        cpu_at.push_back(1);
        cpu_ad.push_back(10'h020);
        cpu_dt.push_back(8'hEE);
        cpu_at.push_back(5);
        cpu_ad.push_back(10'h3F0);
        cpu_dt.push_back(8'h77);
        start_cmd(1'b0, 1'b1, 8'hFF);
        push_done(2817);
        run_op(-1, -1);
        chk("preempt_cell_000", int'(mem[10'h000]), 8'h12);
        chk("preempt_cell_001", int'(mem[10'h001]), 8'h34);
        chk("preempt_cell_3A0", int'(mem[10'h3A0]), 8'hFF);

        // Reset at cycle 100 of a clear, then restart
        for (int p = 0; p <= 99; p++) push_wr(10'(p), 8'h11);
        start_cmd(1'b1, 1'b0, 8'h11);
        run_op(-1, 100);
        @(negedge clk_50mhz);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_vm_we", int'(vm_we), 0);
        chk("midrst_done", int'(done), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_no_done_pending_writes", exp_wr.size(), 0);
        $display("mid-clear reset applied");
        for (int p = 0; p <= 959; p++) push_wr(10'(p), 8'h33);
        start_cmd(1'b1, 1'b0, 8'h33);
        push_done(960);
        run_op(-1, -1);

        for (int i = 0; i < 4; i++) tick();
        chk("final_pending_writes", exp_wr.size(), 0);
        chk("final_pending_done", exp_done.size(), 0);
        bad = 0;
        for (int a = 0; a <= 959; a++) if (mem[a] != shadow[a]) bad++;
        chk("final_image_bad_cells", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
